// File: rtl/add_pkg.sv
`default_nettype none
// ============================================================================
// Module  : add_pkg
// Purpose : Shared defaults and FSM state encoding for the row-add sequencer.
//           c_ADDER_NUM     rows (tokens) per run
//           c_DIMENTION     elements per row
//           c_WIDTH_ADDEND  signed element / sum width
//           c_LANES         elements per beat
// Revision: 1.0  initial release
// ============================================================================
package add_pkg;

    localparam int c_ADDER_NUM    = 128;
    localparam int c_DIMENTION    = 768;
    localparam int c_WIDTH_ADDEND = 8;
    localparam int c_LANES        = 64;

    // Run-control state encoding
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    // Counter width that stays at least one bit for ranges of 1 or 2
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : add_pkg
`default_nettype wire

// File: rtl/add_sat_lane.sv
`default_nettype none
// ============================================================================
// Module  : add_sat_lane
// Purpose : One lane of signed saturating addition (combinational).
// Ports   : a, b  in   WIDTH  signed addends
//           sum   out  WIDTH  a+b clamped to the signed WIDTH range
//           sat   out  1      high when clamping occurred
// Revision: 1.0  initial release
// ============================================================================
module add_sat_lane #(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] sum,
    output logic                    sat
);

    logic [WIDTH:0] w_full;

    // One extra bit holds the exact sum; overflow shows up as the top two
    // bits disagreeing.
    assign w_full = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    assign sat    = w_full[WIDTH] ^ w_full[WIDTH-1];

    always_comb begin
        sum = w_full[WIDTH-1:0];
        if (sat) begin
            // Sign of the exact sum selects which rail to clamp to
            sum = w_full[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

endmodule : add_sat_lane
`default_nettype wire

// File: rtl/add_row_seq.sv
`default_nettype none
// ============================================================================
// Module  : add_row_seq
// Purpose : Streams ADDER_NUM rows of DIMENTION signed elements, LANES per
//           beat, through per-lane saturating adders into one output stage.
// Ports   : clk, rst_n          clock, async active-low reset
//           start               run request (honoured only when idle)
//           in_valid/in_ready   operand handshake, in_a/in_b packed lanes
//           out_valid/out_ready result handshake, out_sum packed lanes
//           out_last_beat       beat is the final one of its row
//           out_last_row        beat belongs to the final row
//           busy, done, sat_flag  run status, end pulse, sticky saturation
// Revision: 1.0  initial release
// ============================================================================
module add_row_seq
    import add_pkg::*;
#(
    parameter int ADDER_NUM    = c_ADDER_NUM,
    parameter int DIMENTION    = c_DIMENTION,
    parameter int WIDTH_ADDEND = c_WIDTH_ADDEND,
    parameter int LANES        = c_LANES
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LANES*WIDTH_ADDEND-1:0]   in_a,
    input  logic [LANES*WIDTH_ADDEND-1:0]   in_b,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LANES*WIDTH_ADDEND-1:0]   out_sum,
    output logic                            out_last_beat,
    output logic                            out_last_row,
    output logic                            busy,
    output logic                            done,
    output logic                            sat_flag
);

    localparam int BEATS = DIMENTION / LANES;
    localparam int BW    = clog2_min1(BEATS);
    localparam int RW    = clog2_min1(ADDER_NUM);
    localparam logic [BW-1:0] c_BEAT_LAST = BW'(BEATS - 1);
    localparam logic [RW-1:0] c_ROW_LAST  = RW'(ADDER_NUM - 1);

    logic [1:0]                    r_state;
    logic [BW-1:0]                 r_beat_cnt;
    logic [RW-1:0]                 r_row_cnt;
    logic                          r_out_valid;
    logic [LANES*WIDTH_ADDEND-1:0] r_out_sum;
    logic                          r_out_last_beat;
    logic                          r_out_last_row;
    logic                          r_done;
    logic                          r_sat_flag;

    logic [LANES*WIDTH_ADDEND-1:0] w_sum;
    logic [LANES-1:0]              w_sat;
    logic                          w_in_ready;
    logic                          w_accept;
    logic                          w_last_beat;
    logic                          w_last_row;

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            add_sat_lane #(
                .WIDTH (WIDTH_ADDEND)
            ) u_lane (
                .a   (in_a [k*WIDTH_ADDEND +: WIDTH_ADDEND]),
                .b   (in_b [k*WIDTH_ADDEND +: WIDTH_ADDEND]),
                .sum (w_sum[k*WIDTH_ADDEND +: WIDTH_ADDEND]),
                .sat (w_sat[k])
            );
        end
    endgenerate

    // A beat may enter whenever the output register is empty or being
    // popped this same cycle, which keeps one beat per cycle sustainable.
    assign w_in_ready  = (r_state == c_RUN) && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && w_in_ready;
    assign w_last_beat = (r_beat_cnt == c_BEAT_LAST);
    assign w_last_row  = (r_row_cnt == c_ROW_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= c_IDLE;
            r_beat_cnt      <= '0;
            r_row_cnt       <= '0;
            r_out_valid     <= 1'b0;
            r_out_sum       <= '0;
            r_out_last_beat <= 1'b0;
            r_out_last_row  <= 1'b0;
            r_done          <= 1'b0;
            r_sat_flag      <= 1'b0;
        end else begin
            r_done <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state    <= c_RUN;
                        r_beat_cnt <= '0;
                        r_row_cnt  <= '0;
                        r_sat_flag <= 1'b0;
                    end
                end
                c_RUN: begin
                    if (w_accept && w_last_beat && w_last_row) begin
                        r_state <= c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    // Leave once the final result has left the output stage
                    if (!r_out_valid || out_ready) begin
                        r_state <= c_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase

            if (w_accept) begin
                if (w_last_beat) begin
                    r_beat_cnt <= '0;
                    r_row_cnt  <= w_last_row ? '0 : r_row_cnt + RW'(1);
                end else begin
                    r_beat_cnt <= r_beat_cnt + BW'(1);
                end
                r_out_valid     <= 1'b1;
                r_out_sum       <= w_sum;
                r_out_last_beat <= w_last_beat;
                r_out_last_row  <= w_last_row;
                if (|w_sat) begin
                    r_sat_flag <= 1'b1;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready      = w_in_ready;
    assign out_valid     = r_out_valid;
    assign out_sum       = r_out_sum;
    assign out_last_beat = r_out_last_beat;
    assign out_last_row  = r_out_last_row;
    assign busy          = (r_state != c_IDLE);
    assign done          = r_done;
    assign sat_flag      = r_sat_flag;

endmodule : add_row_seq
`default_nettype wire

// File: tb/tb_add_row_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_add_row_seq
// Purpose : Self-checking bench for add_row_seq (2 rows x 12 beats x 4 lanes).
// Revision: 1.0  initial release
// ============================================================================
module tb_add_row_seq;

    localparam int AN  = 2;
    localparam int DIM = 48;
    localparam int LN  = 4;
    localparam int W   = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [LN*W-1:0] in_a;
    logic [LN*W-1:0] in_b;
    logic          out_valid;
    logic          out_ready;
    logic [LN*W-1:0] out_sum;
    logic          out_last_beat;
    logic          out_last_row;
    logic          busy;
    logic          done;
    logic          sat_flag;

    int n_checks = 0;
    int n_errors = 0;
    int acc_cnt  = 0;
    int done_cnt = 0;
    int acc0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        logic        sat;
    } vec_t;

    vec_t vecs [5];

    add_row_seq #(
        .ADDER_NUM    (AN),
        .DIMENTION    (DIM),
        .WIDTH_ADDEND (W),
        .LANES        (LN)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_sum       (out_sum),
        .out_last_beat (out_last_beat),
        .out_last_row  (out_last_row),
        .busy          (busy),
        .done          (done),
        .sat_flag      (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) acc_cnt++;
        if (done) done_cnt++;
    end

    function automatic logic [31:0] pk(input int l0, input int l1,
                                       input int l2, input int l3);
        logic [7:0] b0, b1, b2, b3;
        b0 = l0[7:0];
        b1 = l1[7:0];
        b2 = l2[7:0];
        b3 = l3[7:0];
        return {b3, b2, b1, b0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{pk(1, -5, 127, -128),  pk(2, 3, 0, 0),
                    pk(3, -2, 127, -128),  1'b0};
        vecs[1] = '{pk(127, 63, -64, 0),   pk(-128, 64, -64, -1),
                    pk(-1, 127, -128, -1), 1'b0};
        vecs[2] = '{pk(100, -100, -3, 127), pk(50, -50, 5, 1),
                    pk(127, -128, 2, 127),  1'b1};
        vecs[3] = '{pk(-128, 64, 10, -1),  pk(-1, 64, -20, -1),
                    pk(-128, 127, -10, -2), 1'b1};
        vecs[4] = '{pk(0, 0, 0, 0),        pk(0, 0, 0, 0),
                    pk(0, 0, 0, 0),         1'b1};

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b1;

        // Reset state
        #3;
        chk("reset_flags", {25'd0, out_valid, out_last_beat, out_last_row,
                            done, sat_flag, busy, in_ready}, 32'd0);
        chk("reset_sum", out_sum, 32'd0);
        tick();
        rst_n = 1'b1;

        // Operands offered while idle are never taken
        in_valid = 1'b1;
        in_a = pk(1, 1, 1, 1);
        in_b = pk(1, 1, 1, 1);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
            chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
        end
        chk("idle_accepts", acc_cnt, 32'd0);
        in_valid = 1'b0;

        // Run 1: saturation table
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run1_busy", {31'd0, busy}, 32'd1);
        chk("run1_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_a = vecs[i].a;
            in_b = vecs[i].b;
            in_valid = 1'b1;
            tick();
            chk("vec_valid", {31'd0, out_valid}, 32'd1);
            chk("vec_sum", out_sum, vecs[i].s);
            chk("vec_sat", {31'd0, sat_flag}, {31'd0, vecs[i].sat});
            chk("vec_last_beat", {31'd0, out_last_beat}, 32'd0);
        end
        in_valid = 1'b0;
        tick();
        chk("vec_popped", {31'd0, out_valid}, 32'd0);

        // Backpressure: one beat in, then held for 5 cycles
        acc0 = acc_cnt;
        in_a = pk(1, 2, 3, 4);
        in_b = pk(2, 2, 2, 2);
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_sum", out_sum, pk(3, 4, 5, 6));
        end
        chk("bp_accepted", acc_cnt - acc0, 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_popped", {31'd0, out_valid}, 32'd0);

        // start while running is ignored
        acc0 = acc_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rs_busy", {31'd0, busy}, 32'd1);
        chk("rs_accepts", acc_cnt - acc0, 32'd0);

        // Continue from row 0 beat 6 through row 1 beat 5
        in_valid = 1'b1;
        for (int k = 6; k < 18; k++) begin
            in_a = pk(k, k, k, k);
            in_b = pk(1, -1, 2, 0);
            tick();
            chk("seq_sum", out_sum, pk(k + 1, k - 1, k + 2, k));
            chk("seq_last_beat", {31'd0, out_last_beat}, {31'd0, k == 11});
            chk("seq_last_row", {31'd0, out_last_row}, {31'd0, k >= 12});
        end
        in_valid = 1'b0;

        // Asynchronous reset with a beat in flight
        #1 rst_n = 1'b0;
        #1;
        chk("mid_reset_flags", {25'd0, out_valid, out_last_beat, out_last_row,
                                done, sat_flag, busy, in_ready}, 32'd0);
        chk("mid_reset_sum", out_sum, 32'd0);
        #2 rst_n = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("post_reset_in_ready", {31'd0, in_ready}, 32'd0);
            chk("post_reset_out_valid", {31'd0, out_valid}, 32'd0);
        end
        chk("no_done_after_reset", done_cnt, 32'd0);
        in_valid = 1'b0;

        // Run 2: full-throughput streaming of 24 beats
        in_a = pk(5, -7, 100, -128);
        in_b = pk(3, 2, 28, 0);
        start = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            tick();
            chk("tp_valid", {31'd0, out_valid}, 32'd1);
            chk("tp_sum", out_sum, pk(8, -5, 127, -128));
            chk("tp_last_beat", {31'd0, out_last_beat},
                {31'd0, (i == 12) || (i == 24)});
            chk("tp_last_row", {31'd0, out_last_row}, {31'd0, i >= 13});
        end
        tick();
        chk("tp_done", {31'd0, done}, 32'd1);
        chk("tp_idle", {30'd0, busy, out_valid}, 32'd0);
        tick();
        chk("tp_done_pulse", {31'd0, done}, 32'd0);
        chk("tp_done_count", done_cnt, 32'd1);
        chk("tp_sat_held", {31'd0, sat_flag}, 32'd1);
        chk("tp_total_accepts", acc_cnt - acc0, 32'd36);

        // Run 3: a new start clears the sticky saturation flag
        in_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run3_sat_clear", {31'd0, sat_flag}, 32'd0);
        chk("run3_busy", {31'd0, busy}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_add_row_seq
`default_nettype wire
